// File: rtl/sc_register_file.sv
// Integer register file with a post-reset clear sweep and two combinational read ports.
// Define REGFILE_WB_BYPASS_EN for write-first reads; the default build reads the pre-write contents.
module sc_register_file #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4:0]        wb_rd,
  input  logic              wb_we,
  input  logic [DATA_W-1:0] wb_data,
  input  logic [4:0]        rs1_addr,
  input  logic [4:0]        rs2_addr,
  output logic [DATA_W-1:0] rs1_data,
  output logic [DATA_W-1:0] rs2_data,
  output logic              ready
);

  localparam int IDX_W = 5;
  localparam logic [IDX_W-1:0] LAST_IDX = 5'd31;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  state_t state;
  state_t state_next;

  logic [IDX_W-1:0]  clr_idx;
  logic              ready_q;
  logic              wr_en;
  logic [IDX_W-1:0]  wr_idx;
  logic [DATA_W-1:0] wr_val;

  // No reset on the array so it maps onto distributed RAM.
  logic [DATA_W-1:0] regs [NUM_REGS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= CLEAR;
    end else begin
      state <= state_next;
    end
  end

  // One shared write port: the sweep owns it in CLEAR, write-back owns it in RUN.
  always_comb begin
    state_next = state;
    wr_en      = 1'b0;
    wr_idx     = clr_idx;
    wr_val     = '0;
    case (state)
      CLEAR: begin
        wr_en = 1'b1;
        if (clr_idx == LAST_IDX) begin
          state_next = RUN;
        end
      end
      RUN: begin
        wr_en  = wb_we && (wb_rd != '0);
        wr_idx = wb_rd;
        wr_val = wb_data;
      end
      default: state_next = CLEAR;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clr_idx <= 5'd1;
    end else if (state == CLEAR) begin
      clr_idx <= clr_idx + 5'd1;
    end
  end

  // Registered one edge behind the FSM so ready rises on the 32nd edge after release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ready_q <= 1'b0;
    end else begin
      ready_q <= (state == RUN);
    end
  end

  assign ready = ready_q;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      regs[wr_idx] <= wr_val;
    end
  end

  always_comb begin
    rs1_data = regs[rs1_addr];
`ifdef REGFILE_WB_BYPASS_EN
    if (wb_we && (wb_rd != '0) && (rs1_addr == wb_rd)) begin
      rs1_data = wb_data;
    end
`endif
    if ((state == CLEAR) || (rs1_addr == '0)) begin
      rs1_data = '0;
    end
  end

  always_comb begin
    rs2_data = regs[rs2_addr];
`ifdef REGFILE_WB_BYPASS_EN
    if (wb_we && (wb_rd != '0) && (rs2_addr == wb_rd)) begin
      rs2_data = wb_data;
    end
`endif
    if ((state == CLEAR) || (rs2_addr == '0)) begin
      rs2_data = '0;
    end
  end

endmodule

// File: tb/tb_sc_register_file.sv
// Self-checking bench for sc_register_file: clear sweep timing, directed corner cases and
// randomized traffic compared against an array model of the architectural registers.
module tb_sc_register_file;

  localparam int W = 32;

  logic         clk;
  logic         rst;
  logic [4:0]   wb_rd;
  logic         wb_we;
  logic [W-1:0] wb_data;
  logic [4:0]   rs1_addr;
  logic [4:0]   rs2_addr;
  logic [W-1:0] rs1_data;
  logic [W-1:0] rs2_data;
  logic         ready;

  sc_register_file #(.DATA_W(W), .NUM_REGS(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .wb_rd    (wb_rd),
    .wb_we    (wb_we),
    .wb_data  (wb_data),
    .rs1_addr (rs1_addr),
    .rs2_addr (rs2_addr),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .ready    (ready)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // reference model and scoreboard
  logic [W-1:0] model [32];
  logic [W-1:0] exp_q [$];
  int n_cmp = 0;
  int n_err = 0;

`ifdef REGFILE_WB_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] model_read(input logic [4:0] a, input logic we,
                                              input logic [4:0] rd, input logic [W-1:0] d);
    if (a == 5'd0) return '0;
    if (BYPASS && we && rd == a) return d;
    return model[a];
  endfunction

  // driver tasks: inputs change 1 time unit after the rising edge
  task automatic do_cycle(input string tag, input logic we, input logic [4:0] rd,
                          input logic [W-1:0] d, input logic [4:0] a1, input logic [4:0] a2);
    wb_we    = we;
    wb_rd    = rd;
    wb_data  = d;
    rs1_addr = a1;
    rs2_addr = a2;
    #2;
    exp_q.push_back(model_read(a1, we, rd, d));
    exp_q.push_back(model_read(a2, we, rd, d));
    check_eq({tag, "_rs1"}, rs1_data, exp_q.pop_front());
    check_eq({tag, "_rs2"}, rs2_data, exp_q.pop_front());
    @(posedge clk);
    if (we && rd != 5'd0) model[rd] = d;
    #1;
  endtask

  // Releases rst (assumed high) and checks the ready timing; optionally drives a write mid-sweep.
  task automatic run_sweep(input bit write_in_clear);
    rst = 1'b0;
    for (int e = 1; e <= 32; e++) begin
      @(posedge clk);
      #1;
      if (e < 32) check_eq("ready_low_during_sweep", {31'd0, ready}, 32'd0);
      else        check_eq("ready_after_edge32", {31'd0, ready}, 32'd1);
      if (write_in_clear && e == 10) begin
        wb_we   = 1'b1;
        wb_rd   = 5'd7;
        wb_data = 32'h1234_5678;
        rs1_addr = 5'd7;
        #1;
        check_eq("read_forced_zero_in_clear", rs1_data, 32'd0);
      end
      if (e == 20) wb_we = 1'b0;
    end
    wb_we = 1'b0;
    for (int i = 0; i < 32; i++) model[i] = '0;
  endtask

  task automatic read_all_zero(input string tag);
    for (int i = 0; i < 32; i++) begin
      do_cycle(tag, 1'b0, 5'd0, '0, i[4:0], 5'(31 - i));
    end
  endtask

  initial begin
    rst = 1'b1;
    wb_we = 1'b0;
    wb_rd = '0;
    wb_data = '0;
    rs1_addr = '0;
    rs2_addr = '0;
    for (int i = 0; i < 32; i++) model[i] = '0;
    @(posedge clk);
    #1;
    check_eq("ready_in_reset", {31'd0, ready}, 32'd0);
    @(posedge clk);
    #1;

    // clear sweep with a write-back attempt during CLEAR
    run_sweep(1'b1);
    read_all_zero("after_sweep");
    do_cycle("x7_after_clear", 1'b0, 5'd0, '0, 5'd7, 5'd7);

    // basic write/read
    do_cycle("wr_x5", 1'b1, 5'd5, 32'hDEAD_BEEF, 5'd0, 5'd1);
    do_cycle("rd_x5", 1'b0, 5'd0, '0, 5'd5, 5'd5);

    // x0 protection
    do_cycle("x0_write", 1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0);
    do_cycle("x0_later", 1'b0, 5'd0, '0, 5'd0, 5'd5);

    // same-cycle read/write conflict
    do_cycle("wr_x9_old", 1'b1, 5'd9, 32'h1111_1111, 5'd0, 5'd0);
    do_cycle("x9_conflict", 1'b1, 5'd9, 32'h2222_2222, 5'd9, 5'd9);
    do_cycle("x9_next", 1'b0, 5'd0, '0, 5'd9, 5'd9);

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      do_cycle("rand", 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), W'($urandom),
               5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
    end

    // mid-operation reset
    do_cycle("wr_x3", 1'b1, 5'd3, 32'hA5A5_A5A5, 5'd3, 5'd0);
    do_cycle("rd_x3", 1'b0, 5'd0, '0, 5'd3, 5'd3);
    rs1_addr = 5'd3;
    #1;
    rst = 1'b1;
    #1;
    check_eq("ready_async_drop", {31'd0, ready}, 32'd0);
    check_eq("read_zero_in_reset", rs1_data, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    run_sweep(1'b0);
    do_cycle("x3_after_reset", 1'b0, 5'd0, '0, 5'd3, 5'd3);
    read_all_zero("after_resweep");

    for (int n = 0; n < 200; n++) begin
      do_cycle("rand2", 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), W'($urandom),
               5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sc_register_file.md
Name: sc_register_file

Overview:
- Architectural integer register file that terminates the single-cycle write-back interface: accepts destination index, write enable and write data from the write-back stage, and serves two combinational read ports to decode/execute.
- Storage is a sequential array that is cleared by an internal sweep sequencer after reset, so it maps to distributed RAM rather than a reset-per-bit flop array.
- `ready` gates the core's fetch/stall logic until the clear completes.

Parameters:
- DATA_W, 32: register width in bits.
- NUM_REGS, 32: number of registers; fixed at 32 for RV32I, index width 5.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- wb_rd  in  5  destination register index from write-back.
- wb_we  in  1  write enable from write-back.
- wb_data  in  DATA_W  write data from write-back.
- rs1_addr  in  5  read port 1 index.
- rs2_addr  in  5  read port 2 index.
- rs1_data  out  DATA_W  read port 1 data, combinational.
- rs2_data  out  DATA_W  read port 2 data, combinational.
- ready  out  1  high once the clear sweep has finished; the core must stall while it is low.

Behaviour:
- Clock/reset: one clock, `clk`. Reset `rst` is asynchronous and active-high.
- Reset: on `rst` high, the FSM goes to CLEAR, `clr_idx` goes to 1 and `ready` goes to 0. The array contents are not reset directly.
- FSM states: CLEAR and RUN.
- CLEAR:
  - Each cycle, write 0 to `reg[clr_idx]`, then increment `clr_idx`.
  - When `clr_idx` is 31, write it and transition to RUN.
  - The sweep takes 31 cycles after `rst` deasserts; `ready` rises on the 32nd rising edge.
  - Write-back writes are ignored during CLEAR.
  - `rs1_data` and `rs2_data` are forced to 0 during CLEAR.
- RUN:
  - On a rising edge with `wb_we`=1 and `wb_rd`!=0, `reg[wb_rd]` <= `wb_data`.
  - `wb_we`=1 with `wb_rd`=0 is a no-op.
  - `ready` stays 1 until the next `rst`.
- x0: reads of index 0 always return 0, in every state and regardless of bypass. x0 is never written.
- Reads: asynchronous. Same-cycle write/read conflicts are resolved by the optional feature below.
- Reset mid-sweep or mid-RUN:
  - Returns to CLEAR with `clr_idx`=1 and `ready`=0.
  - The full 31-entry sweep restarts; no partial-clear state is retained.
- Both read ports may address the same register, or the same register as the write port, in the same cycle. Each port resolves independently.
- Widths: `wb_data` is stored unmodified; no sign or zero extension is performed in this block.

Optional Feature:
- Macro: REGFILE_WB_BYPASS_EN.
- Defined (write-first bypass), in RUN only:
  - If `wb_we`=1, `wb_rd`!=0 and `rsN_addr`==`wb_rd`, then `rsN_data` = `wb_data` in the same cycle.
  - This lets a pipelined variant read a value being written back in the same cycle without a separate forwarding path.
- Undefined (read-first):
  - `rsN_data` returns the pre-write array contents during the write cycle.
  - The new value is visible from the cycle after the write edge.

Test Plan:
- Clear sweep: assert `rst` 2 cycles, then release. Require `ready`=0 for exactly 31 edges and `ready`=1 after the 32nd. Then read all 32 registers and require every value = 0.
- Basic write/read: in RUN, write x5=0xDEADBEEF. On the next cycle set rs1=5 and rs2=5; require both ports = 0xDEADBEEF.
- x0 protection: write x0=0xFFFFFFFF with `wb_we`=1. Require rs1=0 to read 0 immediately and on later cycles, with and without REGFILE_WB_BYPASS_EN.
- Write during CLEAR: 10 cycles after reset release, drive `wb_we`=1, `wb_rd`=7, `wb_data`=0x12345678. After `ready`=1, require x7 = 0.
- Same-cycle read/write:
  - With x9=0x11111111, in one cycle drive `wb_we`=1, `wb_rd`=9, `wb_data`=0x22222222, with rs1=9 and rs2=9.
  - Require both ports = 0x22222222 when bypass is defined, 0x11111111 when it is undefined.
  - Require 0x22222222 on the next cycle in both builds.
- Mid-operation reset: write x3=0xA5A5A5A5, then assert `rst` during RUN. Require `ready`=0 immediately (asynchronously). After release, require the 31-cycle sweep to repeat and x3 = 0.
